// File: rtl/rename_table.sv
// Register alias table with a free-tag allocator for a two-wide rename stage.
// Source lookups and tag offers are combinational from registered state;
// allocations, retirements and flushes update that state on the clock edge.
module rename_table #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned NUM_TAGS  = 63
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [4:0]           i_q_rs_1       [2],
  input  logic [4:0]           i_q_rs_2       [2],
  input  logic [4:0]           i_q_rd         [2],
  input  logic                 i_q_writes     [2],
  output logic [TAG_WIDTH-1:0] o_rs_1         [2],
  output logic [TAG_WIDTH-1:0] o_rs_2         [2],
  output logic [TAG_WIDTH-1:0] o_rn           [2],
  input  logic                 i_alloc        [2],
  input  logic                 i_commit_valid [2],
  input  logic [4:0]           i_commit_rd    [2],
  input  logic [TAG_WIDTH-1:0] i_commit_tag   [2],
  input  logic                 i_flush,
  output logic [TAG_WIDTH:0]   o_free_count,
  output logic                 o_panic
);

  localparam logic [NUM_TAGS:0] FREE_ALL = {{NUM_TAGS{1'b1}}, 1'b0};

  // Bit 0 of the bitmap stands for the "architectural" tag and is never free.
  logic [TAG_WIDTH-1:0] map_q [ARCH_REGS];
  logic [TAG_WIDTH-1:0] map_n [ARCH_REGS];
  logic [NUM_TAGS:0]    free_q, free_n, offer_mask;
  logic [TAG_WIDTH:0]   count_n;
  logic                 panic_n;
  logic [TAG_WIDTH-1:0] offer0, offer1;
  logic                 alloc_ok [2];
  logic                 commit_ok [2];
  logic                 bad_event;
  logic                 dup_commit;

  function automatic logic [TAG_WIDTH-1:0] lowest_free(input logic [NUM_TAGS:0] v);
    logic [TAG_WIDTH-1:0] r;
    r = '0;
    for (int unsigned t = NUM_TAGS; t > 0; t--) begin
      if (v[t]) r = TAG_WIDTH'(t);
    end
    return r;
  endfunction

  // Zero-latency source lookups; x0 always reads the architectural file.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      o_rs_1[i] = (i_q_rs_1[i] == '0) ? '0 : map_q[i_q_rs_1[i]];
      o_rs_2[i] = (i_q_rs_2[i] == '0) ? '0 : map_q[i_q_rs_2[i]];
    end
  end

  // Offer the two lowest free tags; slot 1 skips slot 0's candidate regardless of need.
  always_comb begin
    offer0             = lowest_free(free_q);
    offer_mask         = free_q;
    offer_mask[offer0] = 1'b0;
    offer1             = lowest_free(offer_mask);
    o_rn[0] = (i_q_writes[0] && (i_q_rd[0] != '0)) ? offer0 : '0;
    o_rn[1] = (i_q_writes[1] && (i_q_rd[1] != '0)) ? offer1 : '0;
  end

  // Next-state: commits clear first so a same-cycle allocation of that rd wins.
  always_comb begin
    map_n      = map_q;
    free_n     = free_q;
    bad_event  = 1'b0;
    dup_commit = i_commit_valid[0] && i_commit_valid[1] &&
                 (i_commit_tag[0] == i_commit_tag[1]);
    if (dup_commit) bad_event = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      alloc_ok[i]  = i_alloc[i] && (o_rn[i] != '0);
      commit_ok[i] = i_commit_valid[i] && (i_commit_tag[i] != '0) &&
                     !free_q[i_commit_tag[i]] && !dup_commit;
      if (i_alloc[i] && (o_rn[i] == '0)) bad_event = 1'b1;
      if (i_commit_valid[i] && ((i_commit_tag[i] == '0) || free_q[i_commit_tag[i]]))
        bad_event = 1'b1;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (commit_ok[i]) begin
        free_n[i_commit_tag[i]] = 1'b1;
        if (map_q[i_commit_rd[i]] == i_commit_tag[i]) map_n[i_commit_rd[i]] = '0;
      end
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (alloc_ok[i]) begin
        free_n[o_rn[i]]  = 1'b0;
        map_n[i_q_rd[i]] = o_rn[i];
      end
    end
    panic_n = o_panic | (bad_event & ~i_flush);
    if (i_flush) begin
      map_n  = '{default: '0};
      free_n = FREE_ALL;
    end
    count_n = '0;
    for (int unsigned t = 1; t <= NUM_TAGS; t++) begin
      count_n = count_n + (TAG_WIDTH + 1)'(free_n[t]);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      map_q        <= '{default: '0};
      free_q       <= FREE_ALL;
      o_free_count <= (TAG_WIDTH + 1)'(NUM_TAGS);
      o_panic      <= 1'b0;
    end else begin
      map_q        <= map_n;
      free_q       <= free_n;
      o_free_count <= count_n;
      o_panic      <= panic_n;
    end
  end

endmodule

// File: tb/tb_rename_table.sv
// Scoreboard bench for rename_table: the driver queues expected outputs per
// cycle, the monitor compares them on the falling edge.
module tb_rename_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] q_rs_1 [2];
  logic [4:0] q_rs_2 [2];
  logic [4:0] q_rd   [2];
  logic       q_writes [2];
  logic [5:0] rs_1 [2];
  logic [5:0] rs_2 [2];
  logic [5:0] rn   [2];
  logic       alloc [2];
  logic       c_valid [2];
  logic [4:0] c_rd  [2];
  logic [5:0] c_tag [2];
  logic       flush;
  logic [6:0] free_count;
  logic       panic;

  rename_table #(.ARCH_REGS(32), .TAG_WIDTH(6), .NUM_TAGS(63)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_q_rs_1(q_rs_1), .i_q_rs_2(q_rs_2), .i_q_rd(q_rd), .i_q_writes(q_writes),
    .o_rs_1(rs_1), .o_rs_2(rs_2), .o_rn(rn),
    .i_alloc(alloc), .i_commit_valid(c_valid), .i_commit_rd(c_rd),
    .i_commit_tag(c_tag), .i_flush(flush),
    .o_free_count(free_count), .o_panic(panic)
  );

  always #5 clk = ~clk;

  typedef enum {K_RS1, K_RS2, K_RN, K_FC, K_PANIC} kind_e;
  typedef struct {
    int    cyc;
    kind_e k;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(kind_e k, int idx);
    case (k)
      K_RS1:   return int'(rs_1[idx]);
      K_RS2:   return int'(rs_2[idx]);
      K_RN:    return int'(rn[idx]);
      K_FC:    return int'(free_count);
      default: return int'(panic);
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.k, e.idx);
      checks++;
      if (e.cyc != cyc || a != e.val) begin
        fails++;
        $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d",
                 e.name, e.idx, e.cyc, a, e.val);
      end
    end
  end

  task automatic ex(kind_e k, int idx, int v, string n);
    exp_t e;
    e.cyc = cyc; e.k = k; e.idx = idx; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      q_rs_1[i] = '0; q_rs_2[i] = '0; q_rd[i] = '0; q_writes[i] = 1'b0;
      alloc[i] = 1'b0; c_valid[i] = 1'b0; c_rd[i] = '0; c_tag[i] = '0;
    end
    flush = 1'b0;
  endtask

  task automatic want(int w0, int r0, int w1, int r1);
    q_writes[0] = w0[0]; q_rd[0] = r0[4:0];
    q_writes[1] = w1[0]; q_rd[1] = r1[4:0];
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    // Reset state and first offers
    step();
    q_rs_1[0] = 5; q_rs_2[0] = 7; want(1, 3, 1, 4);
    ex(K_RS1, 0, 0, "rs1_reset"); ex(K_RS2, 0, 0, "rs2_reset");
    ex(K_RN, 0, 1, "rn_reset");   ex(K_RN, 1, 2, "rn_reset");
    ex(K_FC, 0, 63, "fc_reset");  ex(K_PANIC, 0, 0, "panic_reset");
    step();
    rst_n = 1'b1;
    ex(K_RN, 0, 1, "rn_after_rel"); ex(K_FC, 0, 63, "fc_after_rel");
    // Allocate rd 3 and 4
    step(); clr(); want(1, 3, 1, 4); alloc[0] = 1; alloc[1] = 1;
    ex(K_RN, 0, 1, "rn_alloc34"); ex(K_RN, 1, 2, "rn_alloc34");
    step(); clr();
    q_rs_1[0] = 3; q_rs_2[0] = 4; q_rs_1[1] = 3; q_rs_2[1] = 0; want(1, 7, 1, 0);
    ex(K_RS1, 0, 1, "rs1_map3"); ex(K_RS2, 0, 2, "rs2_map4");
    ex(K_RS1, 1, 1, "rs1_map3"); ex(K_RS2, 1, 0, "rs2_x0");
    ex(K_FC, 0, 61, "fc_two"); ex(K_RN, 0, 3, "rn_next"); ex(K_RN, 1, 0, "rn_rd0");
    // Flush back to a clean table
    step(); clr(); flush = 1;
    step(); clr(); want(1, 9, 1, 9); alloc[0] = 1; alloc[1] = 1; q_rs_1[0] = 3;
    ex(K_RS1, 0, 0, "rs1_flushed"); ex(K_FC, 0, 63, "fc_flushed");
    ex(K_RN, 0, 1, "rn_same_rd"); ex(K_RN, 1, 2, "rn_same_rd");
    // Slot 1 wins rd 9; retiring tag 1 leaves the mapping alone
    step(); clr(); q_rs_1[0] = 9; c_valid[0] = 1; c_rd[0] = 9; c_tag[0] = 1;
    ex(K_RS1, 0, 2, "rs1_slot1_wins"); ex(K_FC, 0, 61, "fc_same_rd");
    step(); clr(); q_rs_1[0] = 9; want(1, 3, 0, 0); alloc[0] = 1;
    ex(K_RS1, 0, 2, "rs1_after_commit"); ex(K_FC, 0, 62, "fc_after_commit");
    ex(K_RN, 0, 1, "rn_tag1_back");
    // Same-cycle commit of rd 3 and new allocation of rd 3
    step(); clr(); q_rs_1[0] = 3; c_valid[0] = 1; c_rd[0] = 3; c_tag[0] = 1;
    want(1, 3, 1, 5); alloc[0] = 1;
    ex(K_RS1, 0, 1, "rs1_map3_t1"); ex(K_FC, 0, 61, "fc_pre_race");
    ex(K_RN, 0, 3, "rn_race"); ex(K_RN, 1, 4, "rn_no_reoffer");
    step(); clr(); q_rs_1[0] = 3; want(1, 6, 1, 7);
    ex(K_RS1, 0, 3, "rs1_alloc_beats_clear"); ex(K_FC, 0, 61, "fc_race");
    ex(K_RN, 0, 1, "rn_tag1_next"); ex(K_RN, 1, 4, "rn_race_next");
    // Flush with simultaneous allocation
    step(); clr(); flush = 1; want(1, 10, 1, 11); alloc[0] = 1; alloc[1] = 1; q_rs_1[0] = 9;
    ex(K_RN, 0, 1, "rn_flush_cyc"); ex(K_RN, 1, 4, "rn_flush_cyc");
    ex(K_RS1, 0, 2, "rs1_pre_flush");
    step(); clr(); q_rs_1[0] = 9; q_rs_1[1] = 3; q_rs_2[0] = 10; q_rs_2[1] = 11;
    want(1, 1, 1, 2);
    ex(K_RS1, 0, 0, "rs1_post_flush"); ex(K_RS1, 1, 0, "rs1_post_flush");
    ex(K_RS2, 0, 0, "rs2_post_flush"); ex(K_RS2, 1, 0, "rs2_post_flush");
    ex(K_FC, 0, 63, "fc_post_flush"); ex(K_RN, 0, 1, "rn_post_flush");
    ex(K_RN, 1, 2, "rn_post_flush"); ex(K_PANIC, 0, 0, "panic_post_flush");
    // Exhaust the free list
    for (int k = 0; k < 31; k++) begin
      step(); clr(); want(1, (k % 31) + 1, 1, ((k + 7) % 31) + 1);
      alloc[0] = 1; alloc[1] = 1;
      ex(K_RN, 0, 2 * k + 1, "rn_exhaust"); ex(K_RN, 1, 2 * k + 2, "rn_exhaust");
      if (k == 0) ex(K_FC, 0, 63, "fc_exhaust_start");
    end
    step(); clr(); want(1, 1, 1, 2); alloc[0] = 1;
    ex(K_RN, 0, 63, "rn_last"); ex(K_RN, 1, 0, "rn_none_slot1"); ex(K_FC, 0, 1, "fc_one");
    step(); clr(); want(1, 5, 0, 0); alloc[0] = 1;
    ex(K_RN, 0, 0, "rn_empty"); ex(K_FC, 0, 0, "fc_empty"); ex(K_PANIC, 0, 0, "panic_before");
    step(); clr(); c_valid[0] = 1; c_rd[0] = 3; c_tag[0] = 5;
    ex(K_PANIC, 0, 1, "panic_alloc_none"); ex(K_FC, 0, 0, "fc_dropped");
    step(); clr(); want(1, 4, 0, 0);
    ex(K_FC, 0, 1, "fc_retire5"); ex(K_PANIC, 0, 1, "panic_sticky"); ex(K_RN, 0, 5, "rn_tag5");
    // Asynchronous reset in mid-cycle
    step(); clr(); q_rs_1[0] = 1; want(1, 1, 1, 2);
    #2 rst_n = 1'b0;
    ex(K_FC, 0, 63, "fc_async_rst"); ex(K_PANIC, 0, 0, "panic_async_rst");
    ex(K_RS1, 0, 0, "rs1_async_rst"); ex(K_RN, 0, 1, "rn_async_rst");
    ex(K_RN, 1, 2, "rn_async_rst");
    step(); rst_n = 1'b1; clr();
    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 5 && sb.size() > 0; w++) step();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
